// File: rtl/slot_master_seq.sv
// Slot-bus initiator: runs one write, read or poll-until-match transaction per command.
// Define SLOT_MASTER_RDBACK_EN to follow every write with a gap cycle and a checking readback.
module slot_master_seq #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int POLL_MAX = 1000,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [DATA_W-1:0] cmd_mask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              cs_o,
  output logic              read_o,
  output logic              write_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic [DATA_W-1:0] rd_data_i
);

  // state | meaning
  // IDLE  | ready for a command
  // ISSUE | one bus strobe cycle, rd_data captured at its end
  // GAP   | idle bus cycle between poll attempts (or before a readback)
  // RSP   | response held until rsp_ready
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_RSP} state_t;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b11;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  lat_addr_q;
  logic [DATA_W-1:0]  data_q, mask_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cmd_ready_q, rsp_valid_q, rsp_err_q, busy_q;
  logic               cs_q, read_q, write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wr_data_q, rsp_data_q;
`ifdef SLOT_MASTER_RDBACK_EN
  logic               rdback_q;
`endif

  logic poll_hit;
  assign poll_hit = ((rd_data_i ^ data_q) & mask_q) == '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      lat_addr_q  <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
`ifdef SLOT_MASTER_RDBACK_EN
      rdback_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            op_q        <= cmd_op_i;
            lat_addr_q  <= cmd_addr_i;
            data_q      <= cmd_data_i;
            mask_q      <= cmd_mask_i;
            cnt_q       <= '0;
`ifdef SLOT_MASTER_RDBACK_EN
            rdback_q    <= 1'b0;
`endif
            if (cmd_op_i == OP_ILL) begin
              state_q     <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state_q <= S_ISSUE;
              cs_q    <= 1'b1;
              addr_q  <= cmd_addr_i;
              if (cmd_op_i == OP_WR) begin
                write_q   <= 1'b1;
                wr_data_q <= cmd_data_i;
              end else begin
                read_q <= 1'b1;
              end
            end
          end
        end
        S_ISSUE: begin
          cs_q      <= 1'b0;
          read_q    <= 1'b0;
          write_q   <= 1'b0;
          addr_q    <= '0;
          wr_data_q <= '0;
          case (op_q)
            OP_WR: begin
`ifdef SLOT_MASTER_RDBACK_EN
              if (!rdback_q) begin
                rdback_q <= 1'b1;
                state_q  <= S_GAP;
              end else begin
                state_q     <= S_RSP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rd_data_i;
                rsp_err_q   <= (rd_data_i != data_q);
              end
`else
              state_q     <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_err_q   <= 1'b0;
`endif
            end
            OP_RD: begin
              state_q     <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rd_data_i;
              rsp_err_q   <= 1'b0;
            end
            default: begin
              if (poll_hit || (cnt_q == CNT_W'(POLL_MAX - 1))) begin
                state_q     <= S_RSP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rd_data_i;
                rsp_err_q   <= !poll_hit;
              end else begin
                cnt_q   <= cnt_q + 1'b1;
                state_q <= S_GAP;
              end
            end
          endcase
        end
        // Only reads follow a gap: further poll attempts or the write readback.
        S_GAP: begin
          state_q <= S_ISSUE;
          cs_q    <= 1'b1;
          read_q  <= 1'b1;
          addr_q  <= lat_addr_q;
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;
  assign cs_o        = cs_q;
  assign read_o      = read_q;
  assign write_o     = write_q;
  assign addr_o      = addr_q;
  assign wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_slot_master_seq.sv
// Directed self-checking bench for slot_master_seq (default build, POLL_MAX=4).
module tb_slot_master_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data, cmd_mask;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_data;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int cs_cnt = 0;
  int viol = 0;
  int poll_base = 0;
  logic        model_mode = 1'b0;
  logic [31:0] model_val = '0;

  always #5 clk = ~clk;

  slot_master_seq #(.ADDR_W(5), .DATA_W(32), .POLL_MAX(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .cs_o(cs), .read_o(rd), .write_o(wr), .addr_o(addr), .wr_data_o(wr_data),
    .rd_data_i(rd_data)
  );

  // Slot model: fixed value, or bit0 set from the third read after poll_base.
  always_comb begin
    rd_data = model_val;
    if (model_mode) rd_data = ((rd_cnt - poll_base) >= 2) ? 32'h0000_00F1 : 32'h0000_00F0;
  end

  always @(posedge clk) begin
    if (cs && rd) rd_cnt <= rd_cnt + 1;
    if (cs && wr) wr_cnt <= wr_cnt + 1;
    if (cs) cs_cnt <= cs_cnt + 1;
  end

  always @(negedge clk) begin
    if ((rd && wr) || ((rd || wr) && !cs) || (!cs && (addr != 0 || wr_data != 0)))
      viol <= viol + 1;
  end

  task automatic issue(input logic [1:0] op, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] m);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, busy, cs, rd, wr, addr, wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b rv=%b rd=%h err=%b busy=%b cs=%b required all 0",
               cmd_ready, rsp_valid, rsp_data, rsp_err, busy, cs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write();
    issue(2'b00, 5'd1, 32'h0000_0064, 32'h0);
    checks++;
    if ({cs, wr, rd, addr, wr_data, busy, cmd_ready} !== {1'b1, 1'b1, 1'b0, 5'd1, 32'h64, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL write_strobe: cs=%b wr=%b rd=%b addr=%0d wdata=%h busy=%b rdy=%b required 1 1 0 1 64 1 0",
               cs, wr, rd, addr, wr_data, busy, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_err, cs} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL write_rsp: rv=%b data=%h err=%b cs=%b required 1 0 0 0", rsp_valid, rsp_data, rsp_err, cs);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL write_min_pulse: rv=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read();
    model_mode = 1'b0; model_val = 32'hDEAD_BEEF;
    issue(2'b01, 5'd2, 32'h0, 32'h0);
    checks++;
    if ({cs, rd, wr, addr, wr_data} !== {1'b1, 1'b1, 1'b0, 5'd2, 32'h0}) begin
      failures++;
      $display("FAIL read_strobe: cs=%b rd=%b wr=%b addr=%0d wdata=%h required 1 1 0 2 0", cs, rd, wr, addr, wr_data);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      failures++;
      $display("FAIL read_rsp: rv=%b data=%h err=%b required 1 deadbeef 0", rsp_valid, rsp_data, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_poll_match();
    int base;
    poll_base = rd_cnt; base = rd_cnt; model_mode = 1'b1;
    issue(2'b10, 5'd3, 32'h1, 32'h1);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (rd !== ((c % 2) == 1) || cs !== ((c % 2) == 1) || busy !== 1'b1 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL poll_match_cycle%0d: rd=%b cs=%b busy=%b rv=%b required %b %b 1 0",
                 c, rd, cs, busy, rsp_valid, (c % 2) == 1, (c % 2) == 1);
      end
      @(negedge clk);
    end
    checks++;
    if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 32'hF1, 1'b0} || (rd_cnt - base) != 3) begin
      failures++;
      $display("FAIL poll_match_rsp: rv=%b data=%h err=%b reads=%0d required 1 f1 0 3",
               rsp_valid, rsp_data, rsp_err, rd_cnt - base);
    end
    model_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_poll_timeout();
    int base;
    base = rd_cnt; model_mode = 1'b0; model_val = 32'h0;
    issue(2'b10, 5'd4, 32'h1, 32'h1);
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (rd !== ((c % 2) == 1) || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL poll_timeout_cycle%0d: rd=%b rv=%b required %b 0", c, rd, rsp_valid, (c % 2) == 1);
      end
      @(negedge clk);
    end
    checks++;
    if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 32'h0, 1'b1} || (rd_cnt - base) != 4) begin
      failures++;
      $display("FAIL poll_timeout_rsp: rv=%b data=%h err=%b reads=%0d required 1 0 1 4",
               rsp_valid, rsp_data, rsp_err, rd_cnt - base);
    end
    @(negedge clk);
  endtask

  task automatic test_mask_zero();
    int base;
    base = rd_cnt; model_val = 32'h0000_1234;
    issue(2'b10, 5'd5, 32'h0000_FFFF, 32'h0);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 32'h1234, 1'b0} || (rd_cnt - base) != 1) begin
      failures++;
      $display("FAIL mask_zero_rsp: rv=%b data=%h err=%b reads=%0d required 1 1234 0 1",
               rsp_valid, rsp_data, rsp_err, rd_cnt - base);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int wbase;
    model_val = 32'hA5A5_0001;
    rsp_ready = 1'b0;
    issue(2'b01, 5'd6, 32'h0, 32'h0);
    @(negedge clk);
    wbase = wr_cnt;
    cmd_op = 2'b00; cmd_addr = 5'd7; cmd_data = 32'h77; cmd_mask = 32'h0; cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({rsp_valid, rsp_data, rsp_err, cmd_ready, cs} !== {1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold_cycle%0d: rv=%b data=%h err=%b rdy=%b cs=%b required 1 a5a50001 0 0 0",
                 c, rsp_valid, rsp_data, rsp_err, cmd_ready, cs);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wr_cnt != wbase) begin
      failures++;
      $display("FAIL hold_release: rv=%b rdy=%b writes=%0d required 0 1 0", rsp_valid, cmd_ready, wr_cnt - wbase);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({cs, wr, addr, wr_data} !== {1'b1, 1'b1, 5'd7, 32'h77}) begin
      failures++;
      $display("FAIL second_cmd_strobe: cs=%b wr=%b addr=%0d wdata=%h required 1 1 7 77", cs, wr, addr, wr_data);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
      failures++;
      $display("FAIL second_cmd_rsp: rv=%b data=%h required 1 0", rsp_valid, rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int cbase;
    cbase = cs_cnt;
    issue(2'b11, 5'd9, 32'hFFFF_FFFF, 32'h0);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, cs} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL illegal_rsp: rv=%b err=%b data=%h cs=%b required 1 1 0 0", rsp_valid, rsp_err, rsp_data, cs);
    end
    @(negedge clk);
    checks++;
    if (cs_cnt != cbase || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_no_strobe: strobes=%0d rv=%b required 0 0", cs_cnt - cbase, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int seen_rsp = 0;
    model_val = 32'h0;
    issue(2'b10, 5'd10, 32'h1, 32'h1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cs !== 1'b0) begin
      failures++;
      $display("FAIL gap_state: busy=%b cs=%b required 1 0", busy, cs);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, cs, rd, wr, rsp_valid, cmd_ready} !== 6'b0) begin
      failures++;
      $display("FAIL async_abort: busy=%b cs=%b rd=%b wr=%b rv=%b rdy=%b required all 0",
               busy, cs, rd, wr, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_abort_ready: rdy=%b busy=%b required 1 0", cmd_ready, busy);
    end
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid !== 1'b0 || cs !== 1'b0) seen_rsp++;
      @(negedge clk);
    end
    checks++;
    if (seen_rsp != 0) begin
      failures++;
      $display("FAIL post_abort_quiet: cycles_with_activity=%0d required 0", seen_rsp);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_poll_match();
    test_poll_timeout();
    test_mask_zero();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL bus_protocol: violations=%0d required 0", viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slot_master_seq.md
Name: slot_master_seq

Overview:
- Bus initiator for the MMIO slot interface (cs/read/write/addr/wr_data/rd_data) used by the slot cores, such as the divider core.
- Accepts single commands from a local sequencer over a valid/ready channel and issues one slot transaction per command: write, read, or poll-until-match.
- Returns the result on a valid/ready response channel.
- Lets hardware sequencers exercise and benchmark slot cores without the CPU.

Parameters:
- ADDR_W, 5, slot register address width
- DATA_W, 32, slot data width
- POLL_MAX, 1000, maximum read attempts in a poll command before timeout (≥1)
- CNT_W, 16, poll attempt counter width (must hold POLL_MAX)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 illegal
- cmd_addr  in  ADDR_W  target slot register
- cmd_data  in  DATA_W  write data / poll compare value
- cmd_mask  in  DATA_W  poll compare mask (ignored for other ops)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  read/poll data; 0 for write
- rsp_err  out  1  timeout, illegal op, or readback mismatch
- busy  out  1  high in any state except IDLE
- cs  out  1  slot select
- read  out  1  slot read strobe
- write  out  1  slot write strobe
- addr  out  ADDR_W  slot address
- wr_data  out  DATA_W  slot write data
- rd_data  in  DATA_W  slot read data, valid combinationally in the same cycle as cs&read

Behaviour:

Reset and interface rules:
- One clock; reset is asynchronous and active-low.
- While reset is asserted, all outputs are 0, including cmd_ready. The FSM is in IDLE and the poll counter is 0.
- All outputs are registered.
- addr and wr_data are 0 whenever cs=0.
- read and write are never high together, and never high without cs.

States: IDLE, ISSUE, GAP, RSP.

- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op/addr/data/mask, clear the poll counter, and go to ISSUE. cmd_ready drops the next cycle.
  - An illegal op goes directly to RSP with rsp_err=1 and rsp_data=0, and issues no bus cycle.
- ISSUE:
  - Exactly one cycle with cs=1, addr=latched addr, plus write=1 with wr_data=latched data, or read=1.
  - rd_data is captured at the end of this cycle.
  - Write → RSP, rsp_data=0, err=0.
  - Read → RSP, rsp_data=captured, err=0.
  - Poll: compare (rd_data & mask) == (data & mask).
    - Match → RSP, rsp_data=captured, err=0.
    - Mismatch with counter+1 == POLL_MAX → RSP, rsp_data=last captured, err=1.
    - Otherwise increment the counter and go to GAP.
- GAP:
  - One idle bus cycle (cs=0), then return to ISSUE.
  - Consecutive poll strobes are therefore 2 cycles apart.
- RSP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE. cmd_ready=1 the following cycle.

Latency:
- Write or read: accept at cycle 0, strobe at cycle 1, rsp_valid at cycle 2.
- Poll matching on attempt k: rsp_valid at cycle 2k.

Boundary conditions:
- cmd_valid while busy is ignored (not accepted).
- rsp_ready held high in advance still gives a minimum 1-cycle rsp_valid pulse.
- POLL_MAX=1: a single attempt; a mismatch times out immediately.
- A mask of 0 always matches on the first attempt.
- Reset mid-transaction aborts immediately: strobes drop asynchronously and no response is produced.

Optional Feature:
- Macro: SLOT_MASTER_RDBACK_EN.
- When defined: every write is followed by one GAP cycle and a read of the same address.
  - rsp_data = readback value.
  - rsp_err=1 if readback ≠ written data.
  - Write latency becomes 4 cycles (accept at 0, write at 1, read at 3, rsp_valid at 4).
- When undefined: a write completes after its single strobe, as specified above.

Test Plan:
- Reset release, then write op, addr=1, data=0x0000_0064 → cycle 1: cs=1, write=1, addr=1, wr_data=0x64. Cycle 2: rsp_valid=1, rsp_data=0, rsp_err=0.
- Read op addr=2 with the slot model driving rd_data=0xDEAD_BEEF → read strobe at cycle 1; rsp_data=0xDEADBEEF at cycle 2, err=0.
- Poll addr=3, mask=0x1, data=0x1; model returns bit0=1 on the 3rd read → exactly 3 read strobes with 1-cycle gaps between them; rsp_valid at cycle 6, err=0.
- Poll with POLL_MAX=4 and a never-matching model returning 0x0 → exactly 4 reads, then rsp_err=1, rsp_data=0.
- Hold rsp_ready=0 for 5 cycles while pushing a second cmd_valid → rsp stays stable, cmd_ready=0, and no second strobe. Then raise rsp_ready → IDLE, and the second command is accepted the next cycle.
- Illegal op 11 → no cs strobe, rsp_err=1 at cycle 1. Separately, drop reset low during a GAP cycle of a poll → all strobes 0 immediately, no response, cmd_ready=1 one cycle after reset release.
